calendar_alarm_core: RTL and testbench
======================================

// Module: calendar_alarm_core
// PURPOSE
//   Parametrised timekeeping core for the digital-clock display chain. Counts
//   sec/min/hour/day-of-week/date/month/year off a 1 s Tick enable, and
//   supports manual field setting and NA independent alarms with snooze.
//   Binary outputs feed the existing 7-segment decode stage.
// PARAMETERS
//   NS          60  seconds per minute (also minutes per hour)
//   NH          24  hours per day
//   NW          7   days per week
//   NM          12  months per year
//   NA          4   number of alarms (>=1)
//   SNOOZE_MIN  5   snooze delay in minutes (1..NS-1)
// PORTS
//   Clk       in   1           system clock, all state on posedge
//   Reset     in   1           asynchronous, active-low reset
//   Tick      in   1           1 s enable, one Clk wide
//   Timeset   in   1           time-set mode
//   Alarmset  in   1           alarm-set mode
//   AlarmSel  in   clog2(NA)   alarm edited in Alarmset
//   Minadv    in   1           advance minutes (time or alarm)
//   Hrsadv    in   1           advance hours (time or alarm)
//   Dayadv    in   1           advance day-of-week
//   Dateadv   in   1           advance date
//   Monthadv  in   1           advance month
//   Yearadv   in   1           advance year
//   Alarmon   in   NA          per-alarm enable
//   Snooze    in   1           snooze all ringing alarms (level, sampled on Clk)
//   Sec/Min   out  6 each      0..NS-1
//   Hr        out  5           0..NH-1
//   Day       out  3           0..NW-1
//   Date      out  5           1..31
//   Month     out  4           1..NM
//   Year      out  7           0..99 (2000..2099)
//   BuzzVec   out  NA          per-alarm ringing flags
//   Buzz      out  1           |BuzzVec
// BEHAVIOUR
//   Reset (async): 00:00:00, Day 0, Date 1, Month 1, Year 0, all alarms 00:00,
//     BuzzVec/Buzz 0, snooze counters idle. Reset mid-run overrides everything.
//   All updates occur on the Clk edge where Tick=1; outputs are registered and
//     reflect the update the next cycle (latency 1). No change when Tick=0.
//   Mode priority: Timeset > Alarmset > run.
//   Timeset: Sec cleared and held at 0; on Tick each asserted *adv advances its
//     own field by 1, wrap with no carry (Min NS-1->0, Hr NH-1->0, Day NW-1->0,
//     Date monthlen->1, Month NM->1, Year 99->0). After Month/Year advance, Date
//     clamps to the new month length (e.g. 01/31 -> 02/28).
//   Alarmset: time runs normally; Minadv/Hrsadv advance alarm[AlarmSel] min/hr
//     with wrap, no carry. Other adv inputs ignored.
//   Run: Sec++; carry chain Sec->Min->Hr->(Date,Day)->Month->Year. Date wraps
//     at monthlen: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb per CONFIG.
//     12/31 23:59:59 -> 01/01 00:00:00, Year+1 (99->0).
//   Alarm k fires when Alarmon[k]=1 and the run-mode Tick lands on
//     Hr==AHr[k], Min==AMin[k], Sec==0: BuzzVec[k] set (latched).
//   Snooze=1 on a Tick-independent Clk edge: every set BuzzVec bit clears and
//     loads its snooze counter with SNOOZE_MIN; counter decrements on each
//     minute rollover; at 0 BuzzVec[k] re-sets. Snooze repeatable.
//   Alarmon[k]=0: BuzzVec[k] and snooze counter k cleared immediately (next edge).
//   Simultaneous Snooze and new match/re-fire for alarm k: set wins.
//   Fires are suppressed while Timeset=1.
// CONFIGURATION
//   LEAP_YEAR_EN defined: Feb length 29 when Year%4==0 (Year 0 = 2000 is leap),
//     else 28; Yearadv to non-leap clamps 02/29 -> 02/28.
//   LEAP_YEAR_EN undefined: Feb always 28 (legacy calendar behaviour).
// TESTING
//   Reset low 2 cycles, release, 1 Tick -> 00:00:01 01/01 Y00, Day 0, Buzz 0.
//   Set 12/31 23:59:59 Y05 Day 6, 1 Tick -> 00:00:00 01/01 Y06 Day 0.
//   02/28 23:59:59 Y04, 1 Tick -> 02/29 with LEAP_YEAR_EN, 03/01 without; Y05 -> 03/01.
//   Timeset, Dateadv at 04/30 -> 04/01 (Month stays 4); Monthadv at 01/31 -> 02/28.
//   Alarm1=07:30, Alarmon=4'b0010, run to 07:30:00 -> BuzzVec=4'b0010, Buzz=1;
//     Snooze -> 0; at 07:35:00 -> 4'b0010 again; Alarmon=0 -> 0.
//   Reset pulsed low mid-count at 13:45:12 -> all outputs to reset values at once.

Source files
------------

// File: rtl/calendar_alarm_core.sv
// Calendar/time-of-day counter with NA snoozable alarms, advanced by a 1 s Tick enable.
// Optional macro LEAP_YEAR_EN: February has 29 days when Year%4==0; otherwise Feb is always 28.
module calendar_alarm_core #(
   parameter int NS         = 60,
   parameter int NH         = 24,
   parameter int NW         = 7,
   parameter int NM         = 12,
   parameter int NA         = 4,
   parameter int SNOOZE_MIN = 5,
   localparam int AW        = (NA > 1) ? $clog2(NA) : 1
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Tick,
   input  logic          Timeset,
   input  logic          Alarmset,
   input  logic [AW-1:0] AlarmSel,
   input  logic          Minadv,
   input  logic          Hrsadv,
   input  logic          Dayadv,
   input  logic          Dateadv,
   input  logic          Monthadv,
   input  logic          Yearadv,
   input  logic [NA-1:0] Alarmon,
   input  logic          Snooze,
   output logic [5:0]    Sec,
   output logic [5:0]    Min,
   output logic [4:0]    Hr,
   output logic [2:0]    Day,
   output logic [4:0]    Date,
   output logic [3:0]    Month,
   output logic [6:0]    Year,
   output logic [NA-1:0] BuzzVec,
   output logic          Buzz
);

   logic [5:0]    sec_q, sec_d, min_q, min_d;
   logic [4:0]    hr_q, hr_d, date_q, date_d;
   logic [2:0]    day_q, day_d;
   logic [3:0]    month_q, month_d;
   logic [6:0]    year_q, year_d;
   logic [5:0]    amin_q [NA];
   logic [5:0]    amin_d [NA];
   logic [4:0]    ahr_q  [NA];
   logic [4:0]    ahr_d  [NA];
   logic [5:0]    snz_q  [NA];
   logic [5:0]    snz_d  [NA];
   logic [NA-1:0] buzz_q, buzz_d;
   logic          buzz_any_q;

   logic          leap_cur, leap_new, min_roll, fire_ok;
   logic [4:0]    mlen_cur, mlen_new, date_t;
   logic [NA-1:0] refire, match;

   function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
         4'd2:                    month_len = leap ? 5'd29 : 5'd28;
         default:                 month_len = 5'd31;
      endcase
   endfunction

`ifdef LEAP_YEAR_EN
   assign leap_cur = (year_q[1:0] == 2'd0);
`else
   assign leap_cur = 1'b0;
`endif

   assign mlen_cur = month_len(month_q, leap_cur);

   always_comb begin
      sec_d    = sec_q;
      min_d    = min_q;
      hr_d     = hr_q;
      day_d    = day_q;
      date_d   = date_q;
      month_d  = month_q;
      year_d   = year_q;
      amin_d   = amin_q;
      ahr_d    = ahr_q;
      leap_new = 1'b0;
      mlen_new = 5'd31;
      date_t   = date_q;
      min_roll = 1'b0;
      fire_ok  = 1'b0;
      if (Tick) begin
         if (Timeset) begin
            sec_d = 6'd0;
            if (Minadv)   min_d   = (min_q == 6'(NS-1)) ? 6'd0 : min_q + 6'd1;
            if (Hrsadv)   hr_d    = (hr_q == 5'(NH-1)) ? 5'd0 : hr_q + 5'd1;
            if (Dayadv)   day_d   = (day_q == 3'(NW-1)) ? 3'd0 : day_q + 3'd1;
            if (Monthadv) month_d = (month_q == 4'(NM)) ? 4'd1 : month_q + 4'd1;
            if (Yearadv)  year_d  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
            if (Dateadv)  date_t  = (date_q >= mlen_cur) ? 5'd1 : date_q + 5'd1;
`ifdef LEAP_YEAR_EN
            leap_new = (year_d[1:0] == 2'd0);
`else
            leap_new = 1'b0;
`endif
            // Month/year changes can shorten the month under the current date.
            mlen_new = month_len(month_d, leap_new);
            date_d   = (date_t > mlen_new) ? mlen_new : date_t;
         end else begin
            fire_ok = 1'b1;
            if (Alarmset) begin
               for (int k = 0; k < NA; k++) begin
                  if (AlarmSel == AW'(k)) begin
                     if (Minadv) amin_d[k] = (amin_q[k] == 6'(NS-1)) ? 6'd0 : amin_q[k] + 6'd1;
                     if (Hrsadv) ahr_d[k]  = (ahr_q[k] == 5'(NH-1)) ? 5'd0 : ahr_q[k] + 5'd1;
                  end
               end
            end
            if (sec_q == 6'(NS-1)) begin
               sec_d    = 6'd0;
               min_roll = 1'b1;
               if (min_q == 6'(NS-1)) begin
                  min_d = 6'd0;
                  if (hr_q == 5'(NH-1)) begin
                     hr_d  = 5'd0;
                     day_d = (day_q == 3'(NW-1)) ? 3'd0 : day_q + 3'd1;
                     if (date_q >= mlen_cur) begin
                        date_d = 5'd1;
                        if (month_q == 4'(NM)) begin
                           month_d = 4'd1;
                           year_d  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                        end else begin
                           month_d = month_q + 4'd1;
                        end
                     end else begin
                        date_d = date_q + 5'd1;
                     end
                  end else begin
                     hr_d = hr_q + 5'd1;
                  end
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end
      end
   end

   // Snooze counters are idle at 0; a count of 1 at a minute rollover means re-ring now.
   always_comb begin
      buzz_d = buzz_q;
      snz_d  = snz_q;
      refire = '0;
      match  = '0;
      for (int k = 0; k < NA; k++) begin
         match[k] = fire_ok && Alarmon[k] && (sec_d == 6'd0) &&
                    (min_d == amin_q[k]) && (hr_d == ahr_q[k]);
         if (Snooze && buzz_q[k]) begin
            buzz_d[k] = 1'b0;
            snz_d[k]  = 6'(SNOOZE_MIN);
         end else if (min_roll && (snz_q[k] != 6'd0)) begin
            snz_d[k] = snz_q[k] - 6'd1;
            if (snz_q[k] == 6'd1) refire[k] = 1'b1;
         end
         if (match[k] || refire[k]) buzz_d[k] = 1'b1;
         if (!Alarmon[k]) begin
            buzz_d[k] = 1'b0;
            snz_d[k]  = 6'd0;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sec_q      <= 6'd0;
         min_q      <= 6'd0;
         hr_q       <= 5'd0;
         day_q      <= 3'd0;
         date_q     <= 5'd1;
         month_q    <= 4'd1;
         year_q     <= 7'd0;
         buzz_q     <= '0;
         buzz_any_q <= 1'b0;
         for (int k = 0; k < NA; k++) begin
            amin_q[k] <= 6'd0;
            ahr_q[k]  <= 5'd0;
            snz_q[k]  <= 6'd0;
         end
      end else begin
         sec_q      <= sec_d;
         min_q      <= min_d;
         hr_q       <= hr_d;
         day_q      <= day_d;
         date_q     <= date_d;
         month_q    <= month_d;
         year_q     <= year_d;
         buzz_q     <= buzz_d;
         buzz_any_q <= |buzz_d;
         for (int k = 0; k < NA; k++) begin
            amin_q[k] <= amin_d[k];
            ahr_q[k]  <= ahr_d[k];
            snz_q[k]  <= snz_d[k];
         end
      end
   end

   assign Sec     = sec_q;
   assign Min     = min_q;
   assign Hr      = hr_q;
   assign Day     = day_q;
   assign Date    = date_q;
   assign Month   = month_q;
   assign Year    = year_q;
   assign BuzzVec = buzz_q;
   assign Buzz    = buzz_any_q;

endmodule

// File: tb/tb_calendar_alarm_core.sv
// Directed bench for calendar_alarm_core: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares them.
module tb_calendar_alarm_core;

   localparam int W = 41;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0, timeset = 1'b0, alarmset = 1'b0;
   logic [1:0] alarm_sel = 2'd0;
   logic       minadv = 1'b0, hrsadv = 1'b0, dayadv = 1'b0, dateadv = 1'b0;
   logic       monthadv = 1'b0, yearadv = 1'b0, snooze = 1'b0;
   logic [3:0] alarmon = 4'd0;
   logic [5:0] sec, min;
   logic [4:0] hr, date;
   logic [2:0] day;
   logic [3:0] month, buzz_vec;
   logic [6:0] year;
   logic       buzz;

   logic [W-1:0] exp_q[$];
   string        lbl_q[$];
   logic         chk = 1'b0;
   int           n_checks = 0;
   int           n_fail = 0;

   calendar_alarm_core dut (
      .Clk(clk), .Reset(rst_n), .Tick(tick), .Timeset(timeset), .Alarmset(alarmset),
      .AlarmSel(alarm_sel), .Minadv(minadv), .Hrsadv(hrsadv), .Dayadv(dayadv),
      .Dateadv(dateadv), .Monthadv(monthadv), .Yearadv(yearadv), .Alarmon(alarmon),
      .Snooze(snooze), .Sec(sec), .Min(min), .Hr(hr), .Day(day), .Date(date),
      .Month(month), .Year(year), .BuzzVec(buzz_vec), .Buzz(buzz)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [W-1:0] pk(input int s, input int mi, input int h, input int d,
                                       input int dt, input int mo, input int y, input logic [3:0] bv);
      pk = {6'(s), 6'(mi), 5'(h), 3'(d), 5'(dt), 4'(mo), 7'(y), bv, |bv};
   endfunction

   // driver tasks
   task automatic clocks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      tick = 1'b0; timeset = 1'b0; alarmset = 1'b0; alarm_sel = 2'd0;
      minadv = 1'b0; hrsadv = 1'b0; dayadv = 1'b0; dateadv = 1'b0;
      monthadv = 1'b0; yearadv = 1'b0; snooze = 1'b0; alarmon = 4'd0;
      clocks(2);
      rst_n = 1'b1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 tick = 1'b1;
         @(posedge clk);
         #1 tick = 1'b0;
      end
   endtask

   // Assumes fields start at 00:00 Day 0 01/01; leaves Timeset asserted.
   task automatic set_time(input int h, input int mi, input int d, input int dt,
                           input int mo, input int y);
      int nmax;
      nmax = h;
      if (mi > nmax) nmax = mi;
      if (d > nmax) nmax = d;
      if (mo - 1 > nmax) nmax = mo - 1;
      if (y > nmax) nmax = y;
      timeset = 1'b1;
      for (int i = 0; i < nmax; i++) begin
         minadv = (i < mi); hrsadv = (i < h); dayadv = (i < d);
         monthadv = (i < mo - 1); yearadv = (i < y);
         tick_n(1);
      end
      minadv = 1'b0; hrsadv = 1'b0; dayadv = 1'b0; monthadv = 1'b0; yearadv = 1'b0;
      dateadv = 1'b1;
      for (int i = 0; i < dt - 1; i++) tick_n(1);
      dateadv = 1'b0;
   endtask

   task automatic expect_vec(input string l, input logic [W-1:0] v);
      exp_q.push_back(v);
      lbl_q.push_back(l);
      chk = 1'b1;
      @(posedge clk);
      #1 chk = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (chk) begin
         logic [W-1:0] act, e;
         string l;
         act = {sec, min, hr, day, date, month, year, buzz_vec, buzz};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL monitor: output presented with no expected entry, got %h", act);
         end else begin
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s: got %h (%0d:%0d:%0d d%0d %0d/%0d y%0d bv%b b%b) expected %h",
                        l, act, hr, min, sec, day, month, date, year, buzz_vec, buzz, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      do_reset();
      expect_vec("reset_state", pk(0, 0, 0, 0, 1, 1, 0, 4'b0000));
      tick_n(1);
      expect_vec("first_tick", pk(1, 0, 0, 0, 1, 1, 0, 4'b0000));

      do_reset();
      set_time(23, 59, 6, 31, 12, 5);
      timeset = 1'b0;
      tick_n(59);
      expect_vec("pre_newyear", pk(59, 59, 23, 6, 31, 12, 5, 4'b0000));
      tick_n(1);
      expect_vec("newyear_rollover", pk(0, 0, 0, 0, 1, 1, 6, 4'b0000));

      do_reset();
      set_time(23, 59, 0, 28, 2, 4);
      timeset = 1'b0;
      tick_n(59);
      expect_vec("pre_feb_y04", pk(59, 59, 23, 0, 28, 2, 4, 4'b0000));
      tick_n(1);
`ifdef LEAP_YEAR_EN
      expect_vec("feb_y04", pk(0, 0, 0, 1, 29, 2, 4, 4'b0000));
`else
      expect_vec("feb_y04", pk(0, 0, 0, 1, 1, 3, 4, 4'b0000));
`endif

      do_reset();
      set_time(23, 59, 0, 28, 2, 5);
      timeset = 1'b0;
      tick_n(60);
      expect_vec("feb_y05", pk(0, 0, 0, 1, 1, 3, 5, 4'b0000));

      do_reset();
      set_time(0, 0, 0, 30, 4, 0);
      dateadv = 1'b1;
      tick_n(1);
      dateadv = 1'b0;
      expect_vec("dateadv_wrap", pk(0, 0, 0, 0, 1, 4, 0, 4'b0000));

      do_reset();
      set_time(0, 0, 0, 31, 1, 1);
      monthadv = 1'b1;
      tick_n(1);
      monthadv = 1'b0;
      expect_vec("monthadv_clamp", pk(0, 0, 0, 0, 28, 2, 1, 4'b0000));

      // Alarm 1 = 07:30; time runs 30 s while it is being set.
      do_reset();
      alarmset = 1'b1;
      alarm_sel = 2'd1;
      for (int i = 0; i < 30; i++) begin
         minadv = 1'b1;
         hrsadv = (i < 7);
         tick_n(1);
      end
      minadv = 1'b0; hrsadv = 1'b0; alarmset = 1'b0;
      set_time(7, 29, 0, 1, 1, 0);
      timeset = 1'b0;
      alarmon = 4'b0010;
      tick_n(59);
      expect_vec("pre_alarm", pk(59, 29, 7, 0, 1, 1, 0, 4'b0000));
      tick_n(1);
      expect_vec("alarm_fire", pk(0, 30, 7, 0, 1, 1, 0, 4'b0010));
      snooze = 1'b1;
      clocks(1);
      snooze = 1'b0;
      expect_vec("snoozed", pk(0, 30, 7, 0, 1, 1, 0, 4'b0000));
      tick_n(299);
      expect_vec("pre_refire", pk(59, 34, 7, 0, 1, 1, 0, 4'b0000));
      tick_n(1);
      expect_vec("snooze_refire", pk(0, 35, 7, 0, 1, 1, 0, 4'b0010));
      alarmon = 4'b0000;
      clocks(1);
      expect_vec("alarmon_off", pk(0, 35, 7, 0, 1, 1, 0, 4'b0000));

      do_reset();
      set_time(13, 45, 0, 1, 1, 0);
      timeset = 1'b0;
      tick_n(12);
      expect_vec("pre_reset", pk(12, 45, 13, 0, 1, 1, 0, 4'b0000));
      rst_n = 1'b0;
      expect_vec("reset_mid", pk(0, 0, 0, 0, 1, 1, 0, 4'b0000));
      rst_n = 1'b1;

      clocks(3);
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
